freq_div_ctrl: RTL and testbench
================================

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 Parameter: DEFAULT_DIV, default 3, divide ratio loaded at reset; legal range 2..15.
REQ-002 clk  input  1  sole clock; counter and FSM on rising edge, half-cycle extension flop on falling edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  run request; 1 = generate divided clock, 0 = stop at next period boundary.
REQ-005 cfg_valid  input  1  new divide ratio offered on cfg_div.
REQ-006 cfg_div  input  4  requested divide ratio N.
REQ-007 cfg_ready  output  1  controller can accept a ratio this cycle.
REQ-008 clk_out  output  1  divided clock, period N clk cycles, 50% duty for even and odd N.
REQ-009 tick  output  1  one-cycle pulse on the first clk cycle of every clk_out period.
REQ-010 div_cur  output  4  ratio currently in effect.
REQ-011 busy  output  1  1 in RUN or SWITCH.
REQ-012 err  output  1  sticky flag: an illegal ratio (<2) was offered and accepted.

Function
REQ-013 FSM states IDLE, RUN, SWITCH; single 4-bit rising-edge period counter cnt, range 0..div_cur-1, wraps to 0 after div_cur-1.
REQ-014 IDLE: cnt=0, clk_out=0, tick=0; en=1 -> RUN at next rising edge, first RUN cycle has cnt=0, tick=1.
REQ-015 RUN: cnt increments each cycle; tick=1 exactly in cycles with cnt==0.
REQ-016 Terminal count TC = (cnt==div_cur-1).
REQ-017 Handshake: transfer occurs when cfg_valid & cfg_ready at a rising edge; cfg_ready=1 in IDLE and RUN, 0 in SWITCH.
REQ-018 Transfer with cfg_div<2: ignored for ratio purposes, err set to 1 next cycle, state unchanged.
REQ-019 Legal transfer in IDLE: div_cur = cfg_div next cycle.
REQ-020 Legal transfer in RUN: cfg_div latched as pending, RUN->SWITCH; div_cur unchanged.
REQ-021 Legal transfer in RUN coinciding with TC: pending still latched, div_cur updated at the next TC, never mid-period.
REQ-022 SWITCH: counting continues with old div_cur; at TC, div_cur=pending, cnt=0, return to RUN; new ratio's first period begins with tick=1.
REQ-023 en=0 in RUN or SWITCH: current period completes; at TC -> IDLE; in SWITCH the pending ratio is still loaded at that TC.
REQ-024 en=1 again before TC: no effect, running continues without gap.
REQ-025 Waveform: pos_hi = 1 in cycles with cnt < floor(div_cur/2); neg_hi = pos_hi resampled on falling clk edge.
REQ-026 clk_out = pos_hi for even div_cur; pos_hi OR neg_hi for odd div_cur; high time N/2 clk periods.
REQ-027 clk_out driven only from flops and the single OR gate; no glitch at a ratio switch.
REQ-028 div_cur=2..15 all produce exact period N; no period is shortened or lengthened at a switch.
REQ-029 busy = (state != IDLE); err cleared only by rst.

Reset
REQ-030 rst=1 asynchronously forces: state=IDLE, cnt=0, pos_hi=0, neg_hi=0, clk_out=0, tick=0, div_cur=DEFAULT_DIV, pending=DEFAULT_DIV, err=0.
REQ-031 After rst release: cfg_ready=1, busy=0.
REQ-032 rst asserted mid-period or in SWITCH: pending ratio discarded, clk_out low immediately.
REQ-033 First rising edge after rst release samples inputs normally.

Verification
REQ-034 Reset then en=1, N=3 -> tick every 3 cycles; clk_out high 1.5 cycles, low 1.5 cycles.
REQ-035 IDLE, offer cfg_div=4 then en=1 -> div_cur=4 next cycle; clk_out high 2, low 2, tick every 4 cycles.
REQ-036 RUN N=5, offer cfg_div=2 at cnt=1 -> cfg_ready=0 until TC; 5-cycle period completes, then 2-cycle periods, tick at switch.
REQ-037 Offer cfg_div=1 (also 0) -> err=1, div_cur unchanged, waveform undisturbed.
REQ-038 RUN N=6, en=0 at cnt=2 -> period completes, IDLE after cnt=5, clk_out=0, busy=0.
REQ-039 rst pulsed mid-SWITCH while clk low -> all outputs at reset values without waiting for an edge, div_cur=3.

Source files
------------

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable 2..15 clock divider with 50% duty for odd and even ratios,
// valid/ready ratio loading and glitch-free switching on period boundaries.
module freq_div_ctrl #(
   parameter int DEFAULT_DIV = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       cfg_valid,
   input  logic [3:0] cfg_div,
   output logic       cfg_ready,
   output logic       clk_out,
   output logic       tick,
   output logic [3:0] div_cur,
   output logic       busy,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
   logic       err_q, err_d, tick_q, tick_d, pos_hi_q, pos_hi_d, neg_hi_q;
   logic       xfer, legal, tc;
   assign cfg_ready = state_q != SWITCH;
   always_comb begin
      xfer    = cfg_valid && cfg_ready;
      legal   = cfg_div >= 4'd2;
      tc      = cnt_q == div_q - 4'd1;
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      err_d   = err_q | (xfer & ~legal);
      case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (xfer && legal) div_d = cfg_div;
            if (en) state_d = RUN;
         end
         RUN: begin
            cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
            if (xfer && legal) begin
               pend_d  = cfg_div;
               state_d = SWITCH;
            end
            // stopping at this boundary: nothing is in flight, so the ratio applies directly
            if (tc && !en) begin
               state_d = IDLE;
               if (xfer && legal) div_d = cfg_div;
            end
         end
         SWITCH: begin
            cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
            if (tc) begin
               div_d   = pend_q;
               state_d = en ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      tick_d   = state_d != IDLE && cnt_d == 4'd0;
      pos_hi_d = state_d != IDLE && cnt_d < (div_d >> 1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         div_q    <= 4'(DEFAULT_DIV);
         pend_q   <= 4'(DEFAULT_DIV);
         err_q    <= 1'b0;
         tick_q   <= 1'b0;
         pos_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         tick_q   <= tick_d;
         pos_hi_q <= pos_hi_d;
      end
   end
   // half-cycle extension only for odd ratios, so the output is a plain OR of two flops
   always_ff @(negedge clk or posedge rst) begin
      if (rst) neg_hi_q <= 1'b0;
      else     neg_hi_q <= pos_hi_q & div_q[0];
   end
   assign clk_out = pos_hi_q | neg_hi_q;
   assign tick    = tick_q;
   assign div_cur = div_q;
   assign busy    = state_q != IDLE;
   assign err     = err_q;
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed scenarios for freq_div_ctrl with per-cycle waveform expectations
// derived from the ratio (high on rising-edge sample for k<N/2, plus k==N/2 when N is odd).
module tb_freq_div_ctrl;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
   logic [3:0] cfg_div = 4'd0;
   logic       cfg_ready, clk_out, tick, busy, err;
   logic [3:0] div_cur;
   int         vecs = 0, errs = 0;
   freq_div_ctrl #(.DEFAULT_DIV(3)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .div_cur(div_cur),
      .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // walk a running divider for a number of cycles starting at period position k0
   task automatic walk(input int n, input int k0, input int cycles, input logic rdy);
      int  k = k0;
      logic er, ef;
      for (int i = 0; i < cycles; i++) begin
         er = (n % 2 == 1) ? (k <= n / 2) : (k < n / 2);
         ef = k < n / 2;
         vecs += 5;
         if (tick !== (k == 0)) begin errs++; $display("FAIL tick n=%0d k=%0d got %b want %b", n, k, tick, k == 0); end
         if (clk_out !== er) begin errs++; $display("FAIL clk_out_rise n=%0d k=%0d got %b want %b", n, k, clk_out, er); end
         if (div_cur !== 4'(n)) begin errs++; $display("FAIL div_cur n=%0d k=%0d got %0d want %0d", n, k, div_cur, n); end
         if (busy !== 1'b1) begin errs++; $display("FAIL busy_run n=%0d k=%0d got %b want 1", n, k, busy); end
         if (cfg_ready !== rdy) begin errs++; $display("FAIL cfg_ready n=%0d k=%0d got %b want %b", n, k, cfg_ready, rdy); end
         @(negedge clk);
         #1;
         vecs++;
         if (clk_out !== ef) begin errs++; $display("FAIL clk_out_fall n=%0d k=%0d got %b want %b", n, k, clk_out, ef); end
         step();
         k = (k == n - 1) ? 0 : k + 1;
      end
   endtask
   task automatic idle_chk(input int n);
      vecs += 5;
      if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
      if (tick !== 1'b0) begin errs++; $display("FAIL idle_tick got %b want 0", tick); end
      if (clk_out !== 1'b0) begin errs++; $display("FAIL idle_clk_out got %b want 0", clk_out); end
      if (cfg_ready !== 1'b1) begin errs++; $display("FAIL idle_ready got %b want 1", cfg_ready); end
      if (div_cur !== 4'(n)) begin errs++; $display("FAIL idle_div got %0d want %0d", div_cur, n); end
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vecs += 5;
      if (clk_out !== 1'b0) begin errs++; $display("FAIL rst_clk_out got %b want 0", clk_out); end
      if (tick !== 1'b0) begin errs++; $display("FAIL rst_tick got %b want 0", tick); end
      if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
      if (err !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", err); end
      if (div_cur !== 4'd3) begin errs++; $display("FAIL rst_div got %0d want 3", div_cur); end
      rst = 1'b0;
      step();
      idle_chk(3);
   endtask
   task automatic test_n3();
      en = 1'b1;
      step();
      walk(3, 0, 9, 1'b1);
      en = 1'b0;
      walk(3, 0, 3, 1'b1);
      idle_chk(3);
   endtask
   task automatic test_load_idle();
      cfg_valid = 1'b1;
      cfg_div = 4'd4;
      step();
      cfg_valid = 1'b0;
      idle_chk(4);
      en = 1'b1;
      step();
      walk(4, 0, 8, 1'b1);
      en = 1'b0;
      walk(4, 0, 4, 1'b1);
      idle_chk(4);
   endtask
   task automatic test_switch();
      cfg_valid = 1'b1;
      cfg_div = 4'd5;
      en = 1'b1;
      step();
      cfg_valid = 1'b0;
      walk(5, 0, 1, 1'b1);
      cfg_valid = 1'b1;
      cfg_div = 4'd2;
      walk(5, 1, 1, 1'b1);
      cfg_valid = 1'b0;
      walk(5, 2, 3, 1'b0);
      walk(2, 0, 6, 1'b1);
   endtask
   task automatic test_err();
      vecs++;
      if (err !== 1'b0) begin errs++; $display("FAIL err_before got %b want 0", err); end
      cfg_valid = 1'b1;
      cfg_div = 4'd1;
      walk(2, 0, 1, 1'b1);
      cfg_div = 4'd0;
      walk(2, 1, 1, 1'b1);
      cfg_valid = 1'b0;
      vecs++;
      if (err !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", err); end
      walk(2, 0, 2, 1'b1);
      en = 1'b0;
      walk(2, 0, 2, 1'b1);
      idle_chk(2);
      vecs++;
      if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", err); end
   endtask
   task automatic test_stop_en();
      cfg_valid = 1'b1;
      cfg_div = 4'd6;
      en = 1'b1;
      step();
      cfg_valid = 1'b0;
      walk(6, 0, 2, 1'b1);
      en = 1'b0;
      walk(6, 2, 1, 1'b1);
      en = 1'b1;
      walk(6, 3, 5, 1'b1);
      en = 1'b0;
      walk(6, 2, 4, 1'b1);
      idle_chk(6);
   endtask
   task automatic test_back_to_back();
      cfg_valid = 1'b1;
      cfg_div = 4'd15;
      en = 1'b1;
      step();
      cfg_valid = 1'b0;
      walk(15, 0, 14, 1'b1);
      cfg_valid = 1'b1;
      cfg_div = 4'd2;
      walk(15, 14, 1, 1'b1);
      cfg_valid = 1'b0;
      walk(15, 0, 15, 1'b0);
      walk(2, 0, 2, 1'b1);
      en = 1'b0;
      walk(2, 0, 2, 1'b1);
      idle_chk(2);
   endtask
   task automatic test_reset_switch();
      cfg_valid = 1'b1;
      cfg_div = 4'd6;
      en = 1'b1;
      step();
      cfg_div = 4'd4;
      walk(6, 0, 1, 1'b1);
      cfg_valid = 1'b0;
      vecs += 2;
      if (cfg_ready !== 1'b0) begin errs++; $display("FAIL sw_ready got %b want 0", cfg_ready); end
      if (busy !== 1'b1) begin errs++; $display("FAIL sw_busy got %b want 1", busy); end
      @(negedge clk);
      #1;
      vecs++;
      if (clk_out !== 1'b1) begin errs++; $display("FAIL sw_clk_high got %b want 1", clk_out); end
      rst = 1'b1;
      en = 1'b0;
      #1;
      vecs += 6;
      if (clk_out !== 1'b0) begin errs++; $display("FAIL arst_clk_out got %b want 0", clk_out); end
      if (tick !== 1'b0) begin errs++; $display("FAIL arst_tick got %b want 0", tick); end
      if (busy !== 1'b0) begin errs++; $display("FAIL arst_busy got %b want 0", busy); end
      if (div_cur !== 4'd3) begin errs++; $display("FAIL arst_div got %0d want 3", div_cur); end
      if (err !== 1'b0) begin errs++; $display("FAIL arst_err got %b want 0", err); end
      if (cfg_ready !== 1'b1) begin errs++; $display("FAIL arst_ready got %b want 1", cfg_ready); end
      step();
      rst = 1'b0;
      step();
      idle_chk(3);
      en = 1'b1;
      step();
      en = 1'b0;
      walk(3, 0, 3, 1'b1);
      idle_chk(3);
   endtask
   initial begin
      test_reset();
      test_n3();
      test_load_idle();
      test_switch();
      test_err();
      test_stop_en();
      test_back_to_back();
      test_reset_switch();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
